// File: rtl/lenet_sched_pkg.sv
// Shared types and defaults for the LeNet ping-pong frame scheduler.
package lenet_sched_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FULL    = 2'd1,
      READING = 2'd2
   } buf_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GO   = 2'd1,
      BUSY = 2'd2
   } sched_state_t;

   localparam int unsigned RESULT_W_DEF = 4;

endpackage

// File: rtl/lenet_sched_wdt.sv
// BUSY watchdog: counts enabled cycles, flags expiry in the LIMIT-th enabled cycle.
module lenet_sched_wdt #(
   parameter int unsigned LIMIT = 2000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] cnt;

   assign expire_c = en && (cnt == CNT_W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expire_c) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lenet_frame_scheduler.sv
// Ping-pong frame buffer scheduler feeding the LeNet core.
// Define LENET_WDT_EN to build in the BUSY watchdog and a live timeout_err.
module lenet_frame_scheduler
   import lenet_sched_pkg::*;
#(
   parameter int unsigned RESULT_W       = RESULT_W_DEF,
   parameter int unsigned DROP_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_done,
   output logic                wr_buf_sel,
   output logic                rd_buf_sel,
   input  logic                lenet_ready,
   output logic                lenet_go,
   input  logic                lenet_done,
   input  logic [RESULT_W-1:0] lenet_result,
   output logic [RESULT_W-1:0] result,
   output logic                result_valid,
   output logic                busy,
   output logic [DROP_W-1:0]   drop_cnt,
   output logic                timeout_err
);

   sched_state_t        state_q, state_d;
   buf_state_t          buf_q [2];
   buf_state_t          buf_d [2];
   logic                wr_d, rd_d, rv_d, to_d;
   logic [DROP_W-1:0]   drop_d;
   logic [RESULT_W-1:0] result_d;
   logic                other_c;
   logic                wdt_expire_c;

   if (TIMEOUT_CYCLES == 0 || DROP_W == 0 || RESULT_W == 0) begin : g_cfg_check
      $error("lenet_frame_scheduler: TIMEOUT_CYCLES, DROP_W and RESULT_W must be nonzero");
   end

`ifdef LENET_WDT_EN
   lenet_sched_wdt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (state_q != BUSY),
      .en       (state_q == BUSY),
      .expire_c (wdt_expire_c)
   );
`else
   assign wdt_expire_c = 1'b0;
`endif

   assign other_c = ~wr_buf_sel;

   // Release/claim first, then frame_done sees the updated buffer states.
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      wr_d     = wr_buf_sel;
      rd_d     = rd_buf_sel;
      rv_d     = 1'b0;
      to_d     = timeout_err;
      drop_d   = drop_cnt;
      result_d = result;

      case (state_q)
         IDLE: begin
            if (lenet_ready && buf_q[other_c] == FULL) begin
               rd_d           = other_c;
               buf_d[other_c] = READING;
               state_d        = GO;
            end
         end
         GO: state_d = BUSY;
         BUSY: begin
            if (lenet_done) begin
               result_d          = lenet_result;
               rv_d              = 1'b1;
               buf_d[rd_buf_sel] = EMPTY;
               state_d           = IDLE;
            end else if (wdt_expire_c) begin
               to_d              = 1'b1;
               buf_d[rd_buf_sel] = EMPTY;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (frame_done) begin
         case (buf_d[other_c])
            EMPTY: begin
               buf_d[wr_buf_sel] = FULL;
               wr_d              = other_c;
            end
            FULL: begin
               buf_d[wr_buf_sel] = FULL;
               buf_d[other_c]    = EMPTY;
               wr_d              = other_c;
               if (drop_cnt != {DROP_W{1'b1}}) drop_d = drop_cnt + DROP_W'(1);
            end
            default: begin
               if (drop_cnt != {DROP_W{1'b1}}) drop_d = drop_cnt + DROP_W'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         buf_q[0]     <= EMPTY;
         buf_q[1]     <= EMPTY;
         wr_buf_sel   <= 1'b0;
         rd_buf_sel   <= 1'b0;
         lenet_go     <= 1'b0;
         busy         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         drop_cnt     <= '0;
         timeout_err  <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         wr_buf_sel   <= wr_d;
         rd_buf_sel   <= rd_d;
         lenet_go     <= (state_d == GO);
         busy         <= (state_d != IDLE);
         result       <= result_d;
         result_valid <= rv_d;
         drop_cnt     <= drop_d;
         timeout_err  <= to_d;
      end
   end

endmodule
